// File: rtl/dmem_mmio.sv
// Data-memory stage: 240-byte RAM at 0x00-0xEF plus a small MMIO block at
// 0xF0-0xFF (output byte FIFO, prescaled timer with compare flag, input port).
//
// Output stream handshake: out_valid is high whenever the FIFO holds at least
// one byte and out_data is then the head byte. A byte is transferred on every
// rising edge where out_valid && out_ready. out_valid never depends
// combinationally on out_ready. A push into an empty FIFO becomes visible on
// the following cycle.
module dmem_mmio #(
  parameter int FIFO_DEPTH = 4,
  parameter int PRESCALE   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       memwrite,
  input  logic [7:0] aluout,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_data
);

  localparam int PTRW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PTRW-1:0] PTR_LAST = PTRW'(FIFO_DEPTH - 1);
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [2:0]      DEPTH_L  = 3'(FIFO_DEPTH);

  localparam logic [7:0] A_OUT    = 8'hF0;
  localparam logic [7:0] A_STATUS = 8'hF1;
  localparam logic [7:0] A_TIMER  = 8'hF2;
  localparam logic [7:0] A_TCMP   = 8'hF3;
  localparam logic [7:0] A_IN     = 8'hF4;

  logic [7:0] mem_q  [0:239];
  logic [7:0] fifo_q [0:FIFO_DEPTH-1];

  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0]      cnt_q, cnt_d;
  logic            ovf_q, ovf_d, match_q, match_d;
  logic [7:0]      timer_q, timer_d, tcmp_q, tcmp_d, in_reg_q, in_reg_d;
  logic [PW-1:0]   presc_q, presc_d;

  logic       is_ram, full, empty, pop, push, push_ok, ovf_set;
  logic       tick, timer_wr, status_wr, match_set;
  logic [7:0] timer_inc, status;

  function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTRW'(1);
  endfunction

  assign is_ram    = (aluout < A_OUT);
  assign full      = (cnt_q == DEPTH_L);
  assign empty     = (cnt_q == 3'd0);
  assign out_valid = !empty;
  assign out_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign status    = {1'b0, cnt_q, match_q, ovf_q, full, empty};

  // Next-state logic for FIFO control, sticky flags, timer and input register.
  always_comb begin
    pop       = !empty && out_ready;
    push      = memwrite && (aluout == A_OUT);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok   = push && (!full || pop);
    ovf_set   = push && full && !pop;
    cnt_d     = cnt_q + {2'b00, push_ok} - {2'b00, pop};
    wr_ptr_d  = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d  = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    tick      = (presc_q == PRE_LAST);
    timer_wr  = memwrite && (aluout == A_TIMER);
    status_wr = memwrite && (aluout == A_STATUS);
    timer_inc = timer_q + 8'd1;
    match_set = 1'b0;
    timer_d   = timer_q;
    presc_d   = presc_q;
    if (timer_wr) begin
      // A load restarts the prescale period and never raises match.
      timer_d = writedata;
      presc_d = '0;
    end else if (tick) begin
      presc_d   = '0;
      timer_d   = timer_inc;
      match_set = (timer_inc == tcmp_q);
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // Set events win over a same-cycle write-1-to-clear.
    ovf_d    = ovf_set   | (ovf_q   & ~(status_wr & writedata[2]));
    match_d  = match_set | (match_q & ~(status_wr & writedata[3]));
    // Compare uses the old TCMP this cycle; the new one applies next cycle.
    tcmp_d   = (memwrite && (aluout == A_TCMP)) ? writedata : tcmp_q;
    in_reg_d = in_data;
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= 3'd0;
      ovf_q    <= 1'b0;
      match_q  <= 1'b0;
      timer_q  <= 8'h00;
      tcmp_q   <= 8'hFF;
      presc_q  <= '0;
      in_reg_q <= 8'h00;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      match_q  <= match_d;
      timer_q  <= timer_d;
      tcmp_q   <= tcmp_d;
      presc_q  <= presc_d;
      in_reg_q <= in_reg_d;
    end
  end

  // Storage arrays: RAM is never cleared; FIFO slots are only written on push.
  always_ff @(posedge clk) begin
    if (memwrite && is_ram) mem_q[aluout] <= writedata;
    if (push_ok && !reset) fifo_q[wr_ptr_q] <= writedata;
  end

  // Combinational load path; RAM reads see the pre-write contents.
  always_comb begin
    readdata = 8'h00;
    if (is_ram) begin
      readdata = mem_q[aluout];
    end else begin
      case (aluout)
        A_STATUS: readdata = status;
        A_TIMER:  readdata = timer_q;
        A_TCMP:   readdata = tcmp_q;
        A_IN:     readdata = in_reg_q;
        default:  readdata = 8'h00;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed scenarios plus randomized traffic, every cycle
// compared against a queue/array reference model of the memory map.
module tb_dmem_mmio;
  localparam int DEPTH = 4;
  localparam int PRE   = 4;

  logic       clk, reset, memwrite, out_ready, out_valid;
  logic [7:0] aluout, writedata, readdata, out_data, in_data;

  dmem_mmio #(.FIFO_DEPTH(DEPTH), .PRESCALE(PRE)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .aluout(aluout),
    .writedata(writedata), .readdata(readdata), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .in_data(in_data)
  );

  // Clock and idle input values
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  // Reference model state
  logic [7:0] ram_m [240];
  bit         ram_k [240];
  logic [7:0] q_m [$];
  bit         ovf_m, match_m;
  int         timer_m, tcmp_m, presc_m;
  logic [7:0] inreg_m;

  logic [7:0] last_rd, last_od;
  logic       last_ov;
  logic       rdy_g;
  logic [7:0] in_g;

  function automatic logic [7:0] status_m();
    int n;
    n = q_m.size();
    return {1'b0, 3'(n), match_m, ovf_m, n == DEPTH, n == 0};
  endfunction

  function automatic logic [7:0] exp_rd(input logic [7:0] a, output bit known);
    known = 1'b1;
    if (a < 8'hF0) begin
      known = ram_k[a];
      return ram_m[a];
    end
    case (a)
      8'hF1:   return status_m();
      8'hF2:   return 8'(timer_m);
      8'hF3:   return 8'(tcmp_m);
      8'hF4:   return inreg_m;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_update(input logic rst, input logic we, input logic [7:0] a,
                              input logic [7:0] d, input logic rdy, input logic [7:0] ind);
    int n;
    bit pop, push, ovf_set, match_set;
    int old_tcmp;
    if (rst) begin
      q_m.delete();
      ovf_m = 0; match_m = 0; timer_m = 0; tcmp_m = 255; presc_m = 0; inreg_m = 8'h00;
      return;
    end
    n = q_m.size();
    pop = (n > 0) && rdy;
    push = we && (a == 8'hF0);
    ovf_set = push && (n == DEPTH) && !pop;
    if (pop) void'(q_m.pop_front());
    if (push && !ovf_set) q_m.push_back(d);
    match_set = 0;
    old_tcmp = tcmp_m;
    if (we && a == 8'hF2) begin
      timer_m = d;
      presc_m = 0;
    end else if (presc_m == PRE - 1) begin
      presc_m = 0;
      timer_m = (timer_m + 1) % 256;
      match_set = (timer_m == old_tcmp);
    end else begin
      presc_m++;
    end
    if (we && a == 8'hF1) begin
      if (d[2]) ovf_m = 0;
      if (d[3]) match_m = 0;
    end
    if (ovf_set) ovf_m = 1;
    if (match_set) match_m = 1;
    if (we && a == 8'hF3) tcmp_m = d;
    if (we && a < 8'hF0) begin
      ram_m[a] = d;
      ram_k[a] = 1;
    end
    inreg_m = ind;
  endtask

  // One clock cycle: drive, check combinational outputs, then advance model.
  task automatic step(input logic rst, input logic we, input logic [7:0] a,
                      input logic [7:0] d, input logic rdy, input logic [7:0] ind);
    logic [7:0] e;
    bit known;
    @(negedge clk);
    reset = rst; memwrite = we; aluout = a; writedata = d; out_ready = rdy; in_data = ind;
    #1;
    last_rd = readdata; last_od = out_data; last_ov = out_valid;
    if (!rst) begin
      e = exp_rd(a, known);
      if (known) check($sformatf("readdata@%02h", a), readdata, e);
      check("out_valid", {7'b0, out_valid}, {7'b0, q_m.size() > 0});
      check("out_data", out_data, (q_m.size() > 0) ? q_m[0] : 8'h00);
    end
    @(posedge clk);
    model_update(rst, we, a, d, rdy, ind);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    step(1'b0, 1'b1, a, d, rdy_g, in_g);
  endtask

  task automatic rd(input logic [7:0] a);
    step(1'b0, 1'b0, a, 8'h00, rdy_g, in_g);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, in_g);
  endtask

  logic [7:0] exp_seq [4];
  logic [7:0] a_r, d_r;
  int         sel;

  // Driver: directed scenarios followed by randomized traffic
  initial begin
    reset = 1'b1; memwrite = 1'b0; aluout = 8'h00; writedata = 8'h00;
    out_ready = 1'b0; in_data = 8'h00;
    rdy_g = 1'b0; in_g = 8'h00;
    do_reset(); do_reset();

    // RAM and idle status
    wr(8'h10, 8'hA5); wr(8'hEF, 8'h3C);
    rd(8'h10); check("ram10", last_rd, 8'hA5);
    rd(8'hEF); check("ramEF", last_rd, 8'h3C);
    rd(8'hF1); check("status_idle", last_rd, 8'h01);

    // Fill, overflow, drain
    rdy_g = 1'b0;
    wr(8'hF0, 8'h11); wr(8'hF0, 8'h22); wr(8'hF0, 8'h33); wr(8'hF0, 8'h44);
    rd(8'hF1); check("status_full", last_rd, 8'h42);
    wr(8'hF0, 8'h55);
    rd(8'hF1); check("status_ovf", last_rd, 8'h46);
    rdy_g = 1'b1;
    exp_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      rd(8'hF7);
      check($sformatf("drain%0d", i), last_od, exp_seq[i]);
    end
    rd(8'hF1); check("drained_valid", {7'b0, last_ov}, 8'h00);
    wr(8'hF1, 8'h04);
    rd(8'hF1); check("ovf_cleared", last_rd, 8'h01);

    // Push into a full FIFO while the head pops
    rdy_g = 1'b0;
    wr(8'hF0, 8'h11); wr(8'hF0, 8'h22); wr(8'hF0, 8'h33); wr(8'hF0, 8'h44);
    step(1'b0, 1'b1, 8'hF0, 8'h99, 1'b1, in_g);
    rd(8'hF1); check("full_push_pop", last_rd, 8'h42);
    rdy_g = 1'b1;
    exp_seq = '{8'h22, 8'h33, 8'h44, 8'h99};
    for (int i = 0; i < 4; i++) begin
      rd(8'hF7);
      check($sformatf("pp_drain%0d", i), last_od, exp_seq[i]);
    end
    rdy_g = 1'b0;

    // Timer compare: match visible after the 12th edge following reset
    do_reset();
    wr(8'hF3, 8'h03);
    for (int i = 2; i <= 12; i++) begin
      rd(8'hF1);
      if (i == 12) check("match_early", {7'b0, last_rd[3]}, 8'h00);
    end
    rd(8'hF1); check("match_set", last_rd, 8'h09);
    wr(8'hF1, 8'h08);
    rd(8'hF1); check("match_clear", last_rd, 8'h01);
    wr(8'hF2, 8'hFF);
    for (int i = 0; i < 4; i++) rd(8'hF2);
    check("timer_pre_wrap", last_rd, 8'hFF);
    rd(8'hF2); check("timer_wrap", last_rd, 8'h00);

    // Input port and unmapped addresses
    in_g = 8'h5A;
    rd(8'hF4);
    rd(8'hF4); check("in_reg", last_rd, 8'h5A);
    rd(8'hF7); check("unmapped", last_rd, 8'h00);
    wr(8'hF4, 8'h77);
    rd(8'hF4); check("in_wr_ignored", last_rd, 8'h5A);

    // Reset with bytes queued
    wr(8'hF0, 8'h01); wr(8'hF0, 8'h02); wr(8'hF0, 8'h03);
    do_reset();
    rd(8'hF1); check("rst_status", last_rd, 8'h01);
    check("rst_valid", {7'b0, last_ov}, 8'h00);
    rd(8'hF2); check("rst_timer", last_rd, 8'h00);
    rd(8'hF3); check("rst_tcmp", last_rd, 8'hFF);
    rd(8'h10); check("rst_ram", last_rd, 8'hA5);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      rdy_g = 1'($urandom_range(0, 1));
      in_g  = 8'($urandom);
      sel   = $urandom_range(0, 9);
      if (sel < 4) a_r = 8'($urandom_range(0, 15));
      else if (sel < 6) a_r = 8'hF0;
      else a_r = 8'hF0 + 8'($urandom_range(1, 15));
      d_r = 8'($urandom);
      if (a_r == 8'hF3) d_r = 8'(timer_m + $urandom_range(1, 3));
      if ($urandom_range(0, 99) == 0) do_reset();
      else step(1'b0, 1'($urandom_range(0, 1)), a_r, d_r, rdy_g, in_g);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
